// File: rtl/alu_lsq_dispatch_queue.sv
//------------------------------------------------------------------------------
// Module      : alu_lsq_dispatch_queue
// Description : Collects every LOAD/STORE result from NUM_CH ALU writeback
//               channels, buffers them in order in a DEPTH-entry circular
//               queue and hands them one per cycle to the load/store queue
//               over a valid/ready handshake.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_lsq_dispatch_queue #(
  parameter int NUM_CH       = 2,
  parameter int OPRAND_WIDTH = 32,
  parameter int OP_WIDTH     = 7,
  parameter int DEPTH        = 8,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_CH-1:0]              valid_i,
  input  logic [NUM_CH*OPRAND_WIDTH-1:0] result_i,
  input  logic [NUM_CH*OP_WIDTH-1:0]     op_func_i,
  output logic                           stall_o,
  output logic                           lsq_valid_o,
  input  logic                           lsq_ready_i,
  output logic [OPRAND_WIDTH-1:0]        address_o,
  output logic                           is_store_o,
  output logic [CH_W-1:0]                ch_o,
  output logic [CNT_W-1:0]               count_o,
  output logic                           overflow_o
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [OP_WIDTH-1:0] c_OP_STORE = OP_WIDTH'(7'b0100011);
  localparam logic [OP_WIDTH-1:0] c_OP_LOAD  = OP_WIDTH'(7'b0000011);

  // Queue storage
  logic [OPRAND_WIDTH-1:0] r_addr  [DEPTH];
  logic                    r_store [DEPTH];
  logic [CH_W-1:0]         r_ch    [DEPTH];

  // Queue bookkeeping
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;

  // Per-channel decode
  logic [OPRAND_WIDTH-1:0] w_res    [NUM_CH];
  logic [OP_WIDTH-1:0]     w_op     [NUM_CH];
  logic [NUM_CH-1:0]       w_is_mem;
  logic [PTR_W-1:0]        w_wr_idx [NUM_CH];

  logic [CNT_W-1:0] w_m;
  logic [CNT_W-1:0] w_free;
  logic             w_stall;
  logic             w_accept;
  logic             w_pop;
  logic             w_valid;

  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      assign w_res[k]    = result_i[k*OPRAND_WIDTH +: OPRAND_WIDTH];
      assign w_op[k]     = op_func_i[k*OP_WIDTH +: OP_WIDTH];
      assign w_is_mem[k] = valid_i[k] &&
                           ((w_op[k] == c_OP_LOAD) || (w_op[k] == c_OP_STORE));
    end
  endgenerate

  // Count memory ops and give each one its slot: a channel lands after all
  // lower-numbered memory ops, so ordering within a cycle is by channel.
  always_comb begin
    w_m = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_wr_idx[k] = r_wr_ptr + w_m[PTR_W-1:0];
      if (w_is_mem[k]) begin
        w_m = w_m + CNT_W'(1);
      end
    end
  end

  // Free space is judged on the start-of-cycle count; a same-cycle pop
  // does not make room until the next cycle.
  assign w_free   = CNT_W'(DEPTH) - r_count;
  assign w_stall  = (w_m > w_free);
  assign w_accept = !w_stall;
  assign w_valid  = (r_count != '0);
  assign w_pop    = w_valid && lsq_ready_i;

  // Pointer, occupancy and sticky overflow tracking
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + w_m[PTR_W-1:0];
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + (w_accept ? w_m : CNT_W'(0)) - CNT_W'(w_pop);
      if (w_stall) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Write every accepted memory op into its slot; contents need no reset
  // because occupancy alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_accept) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (w_is_mem[k]) begin
          r_addr[w_wr_idx[k]]  <= w_res[k];
          r_store[w_wr_idx[k]] <= (w_op[k] == c_OP_STORE);
          r_ch[w_wr_idx[k]]    <= CH_W'(k);
        end
      end
    end
  end

  assign stall_o     = w_stall;
  assign lsq_valid_o = w_valid;
  assign address_o   = w_valid ? r_addr[r_rd_ptr]  : '0;
  assign is_store_o  = w_valid ? r_store[r_rd_ptr] : 1'b0;
  assign ch_o        = w_valid ? r_ch[r_rd_ptr]    : '0;
  assign count_o     = r_count;
  assign overflow_o  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_alu_lsq_dispatch_queue.sv
//------------------------------------------------------------------------------
// Module      : tb_alu_lsq_dispatch_queue
// Description : Directed self-checking bench for alu_lsq_dispatch_queue
//               (NUM_CH=2, DEPTH=8).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_lsq_dispatch_queue;

  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_ADD   = 7'b0110011;

  logic        clk;
  logic        rst;
  logic [1:0]  valid;
  logic [63:0] result;
  logic [13:0] op_func;
  logic        stall;
  logic        lsq_valid;
  logic        lsq_ready;
  logic [31:0] address;
  logic        is_store;
  logic [0:0]  ch;
  logic [3:0]  count;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  alu_lsq_dispatch_queue #(
    .NUM_CH(2), .OPRAND_WIDTH(32), .OP_WIDTH(7), .DEPTH(8)
  ) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .result_i(result),
    .op_func_i(op_func), .stall_o(stall), .lsq_valid_o(lsq_valid),
    .lsq_ready_i(lsq_ready), .address_o(address), .is_store_o(is_store),
    .ch_o(ch), .count_o(count), .overflow_o(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one channel's inputs
  task automatic set_ch(input int k, input logic v, input logic [6:0] op,
                        input logic [31:0] a);
    valid[k]             = v;
    op_func[k*7 +: 7]    = op;
    result[k*32 +: 32]   = a;
    #1;
  endtask

  task automatic idle();
    valid   = '0;
    op_func = '0;
    result  = '0;
    #1;
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; lsq_ready = 1'b0; idle();
    step(); step();
    rst = 1'b0;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (lsq_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", lsq_valid); end
    checks++; if (address !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", address); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
  endtask

  task automatic test_single_load();
    lsq_ready = 1'b1;
    set_ch(0, 1'b1, OP_LOAD, 32'h100);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL single_stall: got %b expected 0", stall); end
    step(); idle();
    checks++; if (lsq_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", lsq_valid); end
    checks++; if (address !== 32'h100) begin errors++; $display("FAIL single_addr: got %h expected 100", address); end
    checks++; if (is_store !== 1'b0) begin errors++; $display("FAIL single_store: got %b expected 0", is_store); end
    checks++; if (ch !== 1'b0) begin errors++; $display("FAIL single_ch: got %0d expected 0", ch); end
    step();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL single_count_after_pop: got %0d expected 0", count); end
    checks++; if (address !== 32'h0) begin errors++; $display("FAIL single_addr_idle: got %h expected 0", address); end
  endtask

  task automatic test_two_ops();
    lsq_ready = 1'b0;
    set_ch(0, 1'b1, OP_STORE, 32'h200);
    set_ch(1, 1'b1, OP_LOAD,  32'h300);
    step(); idle();
    checks++; if (count !== 4'd2) begin errors++; $display("FAIL two_count: got %0d expected 2", count); end
    checks++; if ({address, is_store, ch} !== {32'h200, 1'b1, 1'b0}) begin errors++; $display("FAIL two_head0: got %h/%b/%0d expected 200/1/0", address, is_store, ch); end
    lsq_ready = 1'b1; step(); lsq_ready = 1'b0;
    checks++; if ({address, is_store, ch} !== {32'h300, 1'b0, 1'b1}) begin errors++; $display("FAIL two_head1: got %h/%b/%0d expected 300/0/1", address, is_store, ch); end
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL two_count_pop: got %0d expected 1", count); end
    lsq_ready = 1'b1; step(); lsq_ready = 1'b0;
  endtask

  task automatic test_ignored();
    set_ch(0, 1'b1, OP_ADD,  32'h400);
    set_ch(1, 1'b0, OP_LOAD, 32'h500);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ignored_stall: got %b expected 0", stall); end
    step(); idle();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL ignored_count: got %0d expected 0", count); end
    checks++; if (lsq_valid !== 1'b0) begin errors++; $display("FAIL ignored_valid: got %b expected 0", lsq_valid); end
  endtask

  task automatic test_overflow();
    lsq_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_ch(0, 1'b1, OP_LOAD, 32'h10 + 32'(2*i));
      set_ch(1, 1'b1, OP_LOAD, 32'h11 + 32'(2*i));
      step();
    end
    idle();
    set_ch(0, 1'b1, OP_LOAD, 32'h16);
    step(); idle();
    checks++; if (count !== 4'd7) begin errors++; $display("FAIL ovf_fill: got %0d expected 7", count); end
    set_ch(0, 1'b1, OP_LOAD, 32'h20);
    set_ch(1, 1'b1, OP_STORE, 32'h24);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL ovf_stall: got %b expected 1", stall); end
    step(); idle();
    checks++; if (count !== 4'd7) begin errors++; $display("FAIL ovf_count_hold: got %0d expected 7", count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    set_ch(1, 1'b1, OP_STORE, 32'h28);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ovf_one_stall: got %b expected 0", stall); end
    step(); idle();
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL ovf_full: got %0d expected 8", count); end
  endtask

  task automatic test_full_pop();
    lsq_ready = 1'b1;
    set_ch(0, 1'b1, OP_LOAD, 32'h30);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL full_pop_stall: got %b expected 1", stall); end
    step();
    lsq_ready = 1'b0; #1;
    checks++; if (count !== 4'd7) begin errors++; $display("FAIL full_pop_count: got %0d expected 7", count); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL full_retry_stall: got %b expected 0", stall); end
    step(); idle();
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_retry_count: got %0d expected 8", count); end
    // Queue now holds 0x11..0x16, 0x28 (store, ch1), 0x30
    for (int i = 0; i < 3; i++) begin
      checks++; if (address !== 32'h11 + 32'(i)) begin errors++; $display("FAIL full_order[%0d]: got %h expected %h", i, address, 32'h11 + 32'(i)); end
      lsq_ready = 1'b1; step(); lsq_ready = 1'b0;
    end
  endtask

  task automatic test_reset_midburst();
    checks++; if (count !== 4'd5) begin errors++; $display("FAIL rst_pre_count: got %0d expected 5", count); end
    lsq_ready = 1'b0;
    rst = 1'b1;
    set_ch(0, 1'b1, OP_STORE, 32'hABC);
    step();
    rst = 1'b0; idle();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", count); end
    checks++; if (lsq_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", lsq_valid); end
    checks++; if ({address, is_store, ch} !== 34'h0) begin errors++; $display("FAIL rst_head: got %h/%b/%0d expected 0/0/0", address, is_store, ch); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b expected 0", overflow); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_a [6];
    lsq_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_ch(0, 1'b1, OP_LOAD,  32'h40 + 32'(8*i));
      set_ch(1, 1'b1, OP_STORE, 32'h44 + 32'(8*i));
      step();
    end
    idle();
    lsq_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checks++; if ({address, ch} !== {32'h40 + 32'(4*i), 1'(i % 2)}) begin errors++; $display("FAIL wrap_pre[%0d]: got %h/%0d expected %h/%0d", i, address, ch, 32'h40 + 32'(4*i), i % 2); end
      step();
    end
    lsq_ready = 1'b0;
    exp_a = '{32'hA000_0060, 32'hA000_0064, 32'hB000_0068, 32'hB000_006C, 32'hC000_0070, 32'hC000_0074};
    for (int i = 0; i < 3; i++) begin
      set_ch(0, 1'b1, OP_STORE, exp_a[2*i]);
      set_ch(1, 1'b1, OP_LOAD,  exp_a[2*i+1]);
      step();
    end
    idle();
    checks++; if (count !== 4'd6) begin errors++; $display("FAIL wrap_count: got %0d expected 6", count); end
    lsq_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checks++; if ({address, is_store, ch} !== {exp_a[i], 1'(i % 2 == 0), 1'(i % 2)}) begin errors++; $display("FAIL wrap_post[%0d]: got %h/%b/%0d expected %h/%b/%0d", i, address, is_store, ch, exp_a[i], i % 2 == 0, i % 2); end
      step();
    end
    lsq_ready = 1'b0;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL wrap_drained: got %0d expected 0", count); end
  endtask

  task automatic test_back_to_back();
    lsq_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_ch(1, 1'b1, OP_LOAD, 32'h900 + 32'(i));
      step();
      checks++; if ({count, address, ch} !== {4'd1, 32'h900 + 32'(i), 1'b1}) begin errors++; $display("FAIL b2b[%0d]: got cnt %0d addr %h ch %0d expected 1/%h/1", i, count, address, ch, 32'h900 + 32'(i)); end
    end
    idle();
    step();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL b2b_drain: got %0d expected 0", count); end
    lsq_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; lsq_ready = 1'b0;
    valid = '0; op_func = '0; result = '0;
    test_reset();
    test_single_load();
    test_two_ops();
    test_ignored();
    test_overflow();
    test_full_pop();
    test_reset_midburst();
    test_wrap();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
